// File: rtl/dual_track_crossing_ctrl.sv
// ============================================================================
// Module   : dual_track_crossing_ctrl
// Purpose  : Shared road gate/signal sequencer for a two-track level crossing
//            with per-track occupancy counting, warning, clear-hold and fault.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_track_crossing_ctrl #(
  parameter int WARN_CYCLES    = 4,
  parameter int CLEAR_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_A0,
  input  logic             sensor_B0,
  input  logic             sensor_A1,
  input  logic             sensor_B1,
  output logic             gate,
  output logic             signal,
  output logic             warn,
  output logic             fault,
  output logic [CNT_W-1:0] occ0,
  output logic [CNT_W-1:0] occ1
);

  // One shared timer serves WARN, CLOSED (timeout) and CLEAR.
  localparam int TW = $clog2(WARN_CYCLES + CLEAR_CYCLES + TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] C_OCC_MAX = '1;
  localparam logic [CNT_W-1:0] C_OCC_ONE = CNT_W'(1);
  localparam logic [TW-1:0]    C_TMR_ONE = TW'(1);
  localparam logic [TW-1:0]    C_WARN_END    = TW'(WARN_CYCLES - 1);
  localparam logic [TW-1:0]    C_CLEAR_END   = TW'(CLEAR_CYCLES - 1);
  localparam logic [TW-1:0]    C_TIMEOUT_END = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARN   = 3'd1,
    ST_CLOSED = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [TW-1:0]              r_timer;
  logic [TW-1:0]              w_timer_nxt;
  logic [3:0]                 w_sens;
  logic [3:0]                 r_s_q;
  logic [3:0]                 r_s_qq;
  logic [3:0]                 w_ev;
  logic [1:0][CNT_W-1:0]      r_occ;
  logic [1:0][CNT_W-1:0]      w_occ_nxt;
  logic                       w_cnt_fault;
  logic                       w_arrival;
  logic                       w_any_ev;
  logic                       w_empty;
  logic                       r_gate;
  logic                       r_signal;
  logic                       r_warn;
  logic                       r_fault;

  // Bit order per track t: [2t] = approach (A), [2t+1] = exit (B).
  assign w_sens    = {sensor_B1, sensor_A1, sensor_B0, sensor_A0};
  assign w_ev      = r_s_q & ~r_s_qq;
  assign w_arrival = w_ev[0] | w_ev[2];
  assign w_any_ev  = |w_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_q  <= '0;
      r_s_qq <= '0;
    end else begin
      r_s_q  <= w_sens;
      r_s_qq <= r_s_q;
    end
  end

  always_comb begin
    w_occ_nxt   = r_occ;
    w_cnt_fault = 1'b0;
    for (int t = 0; t < 2; t++) begin
      if (w_ev[2*t] && !w_ev[2*t+1]) begin
        if (r_occ[t] == C_OCC_MAX) w_cnt_fault = 1'b1;
        else                       w_occ_nxt[t] = r_occ[t] + C_OCC_ONE;
      end else if (!w_ev[2*t] && w_ev[2*t+1]) begin
        if (r_occ[t] == '0) w_cnt_fault = 1'b1;
        else                w_occ_nxt[t] = r_occ[t] - C_OCC_ONE;
      end
    end
  end

  assign w_empty = (w_occ_nxt[0] == '0) && (w_occ_nxt[1] == '0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_arrival) w_state_nxt = ST_WARN;
      ST_WARN:   if (r_timer == C_WARN_END) w_state_nxt = ST_CLOSED;
      ST_CLOSED: begin
        if (w_empty)                                    w_state_nxt = ST_CLEAR;
        else if (!w_any_ev && r_timer == C_TIMEOUT_END) w_state_nxt = ST_FAULT;
      end
      ST_CLEAR: begin
        if (w_arrival)                   w_state_nxt = ST_CLOSED;
        else if (r_timer == C_CLEAR_END) w_state_nxt = ST_IDLE;
      end
      ST_FAULT:  w_state_nxt = ST_FAULT;
      default:   w_state_nxt = ST_FAULT;
    endcase
    // Counter faults override whatever transition was chosen above.
    if (w_cnt_fault) w_state_nxt = ST_FAULT;
  end

  always_comb begin
    w_timer_nxt = '0;
    if (w_state_nxt == r_state) begin
      unique case (r_state)
        ST_WARN, ST_CLEAR: w_timer_nxt = r_timer + C_TMR_ONE;
        ST_CLOSED:         w_timer_nxt = w_any_ev ? '0 : r_timer + C_TMR_ONE;
        default:           w_timer_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_occ    <= '0;
      r_gate   <= 1'b0;
      r_signal <= 1'b0;
      r_warn   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_occ    <= w_occ_nxt;
      r_gate   <= (w_state_nxt == ST_CLOSED) || (w_state_nxt == ST_CLEAR) ||
                  (w_state_nxt == ST_FAULT);
      r_signal <= (w_state_nxt != ST_IDLE);
      r_warn   <= (w_state_nxt == ST_WARN);
      r_fault  <= (w_state_nxt == ST_FAULT);
    end
  end

  assign gate   = r_gate;
  assign signal = r_signal;
  assign warn   = r_warn;
  assign fault  = r_fault;
  assign occ0   = r_occ[0];
  assign occ1   = r_occ[1];

endmodule

`default_nettype wire

// File: tb/tb_dual_track_crossing_ctrl.sv
// ============================================================================
// Module   : tb_dual_track_crossing_ctrl
// Purpose  : Directed self-checking bench for dual_track_crossing_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_track_crossing_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_A0 = 1'b0, sensor_B0 = 1'b0, sensor_A1 = 1'b0, sensor_B1 = 1'b0;
  logic       gate, signal, warn, fault;
  logic [1:0] occ0, occ1;
  int         n_vec = 0;
  int         n_err = 0;

  dual_track_crossing_ctrl #(
    .WARN_CYCLES(4), .CLEAR_CYCLES(3), .TIMEOUT_CYCLES(64), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset),
    .sensor_A0(sensor_A0), .sensor_B0(sensor_B0),
    .sensor_A1(sensor_A1), .sensor_B1(sensor_B1),
    .gate(gate), .signal(signal), .warn(warn), .fault(fault),
    .occ0(occ0), .occ1(occ1)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    sensor_A0 = 1'b0; sensor_B0 = 1'b0; sensor_A1 = 1'b0; sensor_B1 = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  // One train on track 0 into CLOSED: returns at the first negedge with gate=1.
  task automatic enter_closed_t0();
    sensor_A0 = 1'b1; step(2);
    sensor_A0 = 1'b0; step(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    n_vec++; if ({gate, signal, warn, fault, occ0, occ1} !== 8'h00) begin n_err++;
      $display("FAIL reset_vals: got %b exp 00000000", {gate, signal, warn, fault, occ0, occ1}); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    apply_reset();
    sensor_A0 = 1'b1; step(1);
    n_vec++; if (warn !== 1'b0) begin n_err++; $display("FAIL single_warn_early: got %b exp 0", warn); end
    step(1);
    n_vec++; if ({warn, signal, gate, occ0} !== 5'b11001) begin n_err++;
      $display("FAIL single_warn_start: got %b exp 11001", {warn, signal, gate, occ0}); end
    sensor_A0 = 1'b0; step(3);
    n_vec++; if ({warn, gate} !== 2'b10) begin n_err++; $display("FAIL single_warn_last: got %b exp 10", {warn, gate}); end
    step(1);
    n_vec++; if ({warn, gate} !== 2'b01) begin n_err++; $display("FAIL single_gate_down: got %b exp 01", {warn, gate}); end
    step(2);
    sensor_B0 = 1'b1; step(2);
    n_vec++; if ({occ0, gate} !== 3'b001) begin n_err++; $display("FAIL single_exit: got %b exp 001", {occ0, gate}); end
    sensor_B0 = 1'b0; step(2);
    n_vec++; if (gate !== 1'b1) begin n_err++; $display("FAIL single_clear_hold: got %b exp 1", gate); end
    step(1);
    n_vec++; if ({gate, signal, fault} !== 3'b000) begin n_err++;
      $display("FAIL single_reopen: got %b exp 000", {gate, signal, fault}); end
  endtask

  task automatic test_overlap();
    apply_reset();
    enter_closed_t0();
    sensor_A1 = 1'b1; step(2);
    n_vec++; if ({occ0, occ1, gate} !== 5'b01011) begin n_err++;
      $display("FAIL overlap_peak: got %b exp 01011", {occ0, occ1, gate}); end
    sensor_A1 = 1'b0; sensor_B0 = 1'b1; step(2);
    n_vec++; if ({occ0, occ1, gate} !== 5'b00011) begin n_err++;
      $display("FAIL overlap_b0: got %b exp 00011", {occ0, occ1, gate}); end
    sensor_B0 = 1'b0; sensor_B1 = 1'b1; step(2);
    n_vec++; if ({occ1, gate} !== 3'b001) begin n_err++; $display("FAIL overlap_b1: got %b exp 001", {occ1, gate}); end
    sensor_B1 = 1'b0; step(2);
    n_vec++; if (gate !== 1'b1) begin n_err++; $display("FAIL overlap_clear_late: got %b exp 1", gate); end
    step(1);
    n_vec++; if (gate !== 1'b0) begin n_err++; $display("FAIL overlap_reopen: got %b exp 0", gate); end
  endtask

  task automatic test_rearrival();
    apply_reset();
    enter_closed_t0();
    sensor_B0 = 1'b1; step(1);
    sensor_A1 = 1'b1; step(1);
    n_vec++; if ({occ0, gate, warn} !== 4'b0010) begin n_err++;
      $display("FAIL rearr_clear: got %b exp 0010", {occ0, gate, warn}); end
    sensor_B0 = 1'b0; step(1);
    n_vec++; if ({occ1, gate, warn} !== 4'b0110) begin n_err++;
      $display("FAIL rearr_closed: got %b exp 0110", {occ1, gate, warn}); end
    sensor_A1 = 1'b0; sensor_B1 = 1'b1; step(2);
    n_vec++; if ({occ1, gate, warn} !== 4'b0010) begin n_err++;
      $display("FAIL rearr_hold: got %b exp 0010", {occ1, gate, warn}); end
    sensor_B1 = 1'b0; step(2);
    n_vec++; if (gate !== 1'b1) begin n_err++; $display("FAIL rearr_clear2: got %b exp 1", gate); end
    step(1);
    n_vec++; if (gate !== 1'b0) begin n_err++; $display("FAIL rearr_reopen: got %b exp 0", gate); end
  endtask

  task automatic test_spurious();
    apply_reset();
    sensor_B1 = 1'b1; step(1);
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL spur_early: got %b exp 0", fault); end
    step(1);
    n_vec++; if ({fault, gate, signal, warn, occ1} !== 6'b111000) begin n_err++;
      $display("FAIL spur_fault: got %b exp 111000", {fault, gate, signal, warn, occ1}); end
    sensor_B1 = 1'b0; step(2);
    sensor_A1 = 1'b1; step(2);
    sensor_A1 = 1'b0;
    n_vec++; if ({occ1, fault, warn} !== 4'b0110) begin n_err++;
      $display("FAIL spur_count_in_fault: got %b exp 0110", {occ1, fault, warn}); end
    step(10);
    n_vec++; if ({fault, gate, signal} !== 3'b111) begin n_err++;
      $display("FAIL spur_sticky: got %b exp 111", {fault, gate, signal}); end
  endtask

  task automatic test_timeout();
    apply_reset();
    enter_closed_t0();
    n_vec++; if ({gate, fault} !== 2'b10) begin n_err++; $display("FAIL to_closed: got %b exp 10", {gate, fault}); end
    step(63);
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL to_early: got %b exp 0", fault); end
    step(1);
    n_vec++; if ({fault, gate} !== 2'b11) begin n_err++; $display("FAIL to_fire: got %b exp 11", {fault, gate}); end
    apply_reset();
    enter_closed_t0();
    step(10);
    sensor_A1 = 1'b1; step(2);
    sensor_A1 = 1'b0;
    n_vec++; if (occ1 !== 2'd1) begin n_err++; $display("FAIL to_a1: got %0d exp 1", occ1); end
    step(63);
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL to_restart_early: got %b exp 0", fault); end
    step(1);
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL to_restart_fire: got %b exp 1", fault); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    enter_closed_t0();
    n_vec++; if ({gate, occ0} !== 3'b101) begin n_err++; $display("FAIL ar_pre: got %b exp 101", {gate, occ0}); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if ({gate, signal, warn, fault, occ0, occ1} !== 8'h00) begin n_err++;
      $display("FAIL ar_closed: got %b exp 00000000", {gate, signal, warn, fault, occ0, occ1}); end
    #1 reset = 1'b0;
    step(1);
    n_vec++; if ({gate, signal} !== 2'b00) begin n_err++; $display("FAIL ar_after: got %b exp 00", {gate, signal}); end
    sensor_B0 = 1'b1; step(2);
    sensor_B0 = 1'b0;
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL ar_mkfault: got %b exp 1", fault); end
    #2 reset = 1'b1;
    #1;
    n_vec++; if ({fault, gate} !== 2'b00) begin n_err++; $display("FAIL ar_fault: got %b exp 00", {fault, gate}); end
    #1 reset = 1'b0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    enter_closed_t0();
    sensor_A0 = 1'b1; sensor_B0 = 1'b1; step(2);
    n_vec++; if ({occ0, fault, gate} !== 4'b0101) begin n_err++;
      $display("FAIL simul_ab: got %b exp 0101", {occ0, fault, gate}); end
    sensor_A0 = 1'b0; sensor_B0 = 1'b0; step(3);
    n_vec++; if ({occ0, fault} !== 3'b010) begin n_err++; $display("FAIL simul_fall: got %b exp 010", {occ0, fault}); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      sensor_A0 = 1'b1; step(1);
      sensor_A0 = 1'b0; step(1);
    end
    n_vec++; if ({occ0, fault} !== 3'b110) begin n_err++; $display("FAIL sat_max: got %b exp 110", {occ0, fault}); end
    sensor_A0 = 1'b1; step(1);
    sensor_A0 = 1'b0; step(1);
    n_vec++; if ({occ0, fault, gate} !== 4'b1111) begin n_err++;
      $display("FAIL sat_over: got %b exp 1111", {occ0, fault, gate}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_rearrival();
    test_spurious();
    test_timeout();
    test_async_reset();
    test_simultaneous();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
